// File: rtl/multicycle_controller.sv
// Multicycle instruction-phase controller: fetch/decode/execute/memory/writeback/PC sequencing
// with a memory-wait watchdog. Define PERF_COUNT_EN to add retired/stall performance counters.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       run,
  input  logic [2:0] opClass,
  input  logic       memReady,
  output logic [2:0] state,
  output logic       irWriteEnable,
  output logic       regsWriteEnable,
  output logic       memReadEnable,
  output logic       memWriteEnable,
  output logic       pcWriteEnable,
  output logic       busy,
  output logic       illegalOp,
`ifdef PERF_COUNT_EN
  output logic       memTimeout,
  output logic [31:0] retiredCount,
  output logic [31:0] stallCount
`else
  output logic       memTimeout
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEMRD  = 3'd4,
    S_MEMWR  = 3'd5,
    S_WB     = 3'd6,
    S_PCUPD  = 3'd7
  } state_e;

  localparam logic [2:0] OP_ALU    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_JUMP   = 3'd4;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  logic             waiting;
  logic             wait_expired;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ALU;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // memReady on the expiring cycle still completes the access normally
  always_comb begin
    waiting      = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    wait_expired = waiting && !memReady && (cnt_q == WAIT_LAST);
    cnt_inc      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (run && !illegal_q && !timeout_q) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end

      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (memReady) begin
          cnt_d = '0;
          if (state_q == S_FETCH)      state_d = S_DECODE;
          else if (state_q == S_MEMRD) state_d = S_WB;
          else                         state_d = S_PCUPD;
        end else if (wait_expired) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DECODE: begin
        if (opClass <= OP_JUMP) begin
          op_d    = opClass;
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_EXEC: begin
        cnt_d = '0;
        unique case (op_q)
          OP_LOAD:   state_d = S_MEMRD;
          OP_STORE:  state_d = S_MEMWR;
          OP_BRANCH: state_d = S_PCUPD;
          default:   state_d = S_WB;
        endcase
      end

      S_WB: state_d = S_PCUPD;

      S_PCUPD: begin
        cnt_d   = '0;
        state_d = run ? S_FETCH : S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    irWriteEnable   = 1'b0;
    regsWriteEnable = 1'b0;
    memReadEnable   = 1'b0;
    memWriteEnable  = 1'b0;
    pcWriteEnable   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        memReadEnable = 1'b1;
        irWriteEnable = memReady;
      end
      S_MEMRD: memReadEnable   = 1'b1;
      S_MEMWR: memWriteEnable  = 1'b1;
      S_WB:    regsWriteEnable = 1'b1;
      S_PCUPD: pcWriteEnable   = 1'b1;
      default: ;
    endcase
  end

  assign state      = state_q;
  assign busy       = (state_q != S_IDLE);
  assign illegalOp  = illegal_q;
  assign memTimeout = timeout_q;

`ifdef PERF_COUNT_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if (state_q == S_PCUPD) retired_d = retired_q + 32'd1;
    if (waiting && !memReady) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retiredCount = retired_q;
  assign stallCount   = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller against an instruction-level phase-plan model.
module tb_multicycle_controller;

  localparam int TO = 16;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3;
  localparam int P_MEMRD = 4, P_MEMWR = 5, P_WB = 6, P_PCUPD = 7;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       run = 1'b0;
  logic [2:0] opClass = 3'd0;
  logic       memReady = 1'b0;
  logic [2:0] state;
  logic       irWriteEnable, regsWriteEnable, memReadEnable, memWriteEnable;
  logic       pcWriteEnable, busy, illegalOp, memTimeout;
`ifdef PERF_COUNT_EN
  logic [31:0] retiredCount, stallCount;
`endif

  multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk),
    .rstn(rstn),
    .run(run),
    .opClass(opClass),
    .memReady(memReady),
    .state(state),
    .irWriteEnable(irWriteEnable),
    .regsWriteEnable(regsWriteEnable),
    .memReadEnable(memReadEnable),
    .memWriteEnable(memWriteEnable),
    .pcWriteEnable(pcWriteEnable),
    .busy(busy),
    .illegalOp(illegalOp),
`ifdef PERF_COUNT_EN
    .memTimeout(memTimeout),
    .retiredCount(retiredCount),
    .stallCount(stallCount)
`else
    .memTimeout(memTimeout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          m_phase;
  int          m_wait;
  int          plan[$];
  bit          m_ill, m_to;
  logic [31:0] m_ret, m_stall;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_phase = P_IDLE;
    m_wait  = 0;
    plan.delete();
    m_ill   = 1'b0;
    m_to    = 1'b0;
    m_ret   = '0;
    m_stall = '0;
  endtask

  task automatic applyStimulus(input int readyPct, input int runPct);
    run      = (int'($urandom_range(99)) < runPct);
    memReady = (int'($urandom_range(99)) < readyPct);
    if ($urandom_range(99) < 92) opClass = 3'($urandom_range(4));
    else                         opClass = 3'($urandom_range(7, 5));
  endtask

  task automatic checkAll();
    checkOutput("state", 32'(state), 32'(m_phase));
    checkOutput("busy", 32'(busy), 32'(m_phase != P_IDLE));
    checkOutput("memRead", 32'(memReadEnable), 32'(m_phase == P_FETCH || m_phase == P_MEMRD));
    checkOutput("memWrite", 32'(memWriteEnable), 32'(m_phase == P_MEMWR));
    checkOutput("regsWrite", 32'(regsWriteEnable), 32'(m_phase == P_WB));
    checkOutput("pcWrite", 32'(pcWriteEnable), 32'(m_phase == P_PCUPD));
    checkOutput("irWrite", 32'(irWriteEnable), 32'(m_phase == P_FETCH && memReady));
    checkOutput("illegalOp", 32'(illegalOp), 32'(m_ill));
    checkOutput("memTimeout", 32'(memTimeout), 32'(m_to));
`ifdef PERF_COUNT_EN
    checkOutput("retired", retiredCount, m_ret);
    checkOutput("stall", stallCount, m_stall);
`endif
  endtask

  // One instruction is a fixed list of phases chosen at decode; memory phases may stretch or abort
  task automatic modelStep();
    case (m_phase)
      P_IDLE: begin
        if (run && !m_ill && !m_to) begin
          m_phase = P_FETCH;
          m_wait  = 0;
        end
      end
      P_FETCH, P_MEMRD, P_MEMWR: begin
        if (memReady) begin
          m_wait  = 0;
          m_phase = (m_phase == P_FETCH) ? P_DECODE : plan.pop_front();
        end else begin
          m_stall = m_stall + 32'd1;
          m_wait++;
          if (m_wait >= TO) begin
            m_to    = 1'b1;
            m_phase = P_IDLE;
            plan.delete();
          end
        end
      end
      P_DECODE: begin
        plan.delete();
        case (opClass)
          3'd0, 3'd4: plan = '{P_EXEC, P_WB, P_PCUPD};
          3'd1:       plan = '{P_EXEC, P_MEMRD, P_WB, P_PCUPD};
          3'd2:       plan = '{P_EXEC, P_MEMWR, P_PCUPD};
          3'd3:       plan = '{P_EXEC, P_PCUPD};
          default:    m_ill = 1'b1;
        endcase
        m_phase = m_ill ? P_IDLE : plan.pop_front();
      end
      P_PCUPD: begin
        m_ret   = m_ret + 32'd1;
        m_wait  = 0;
        m_phase = run ? P_FETCH : P_IDLE;
      end
      default: m_phase = plan.pop_front();
    endcase
  endtask

  task automatic doReset();
    @(negedge clk);
    run      = 1'b0;
    memReady = 1'b0;
    rstn     = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int readyTable[5];
    int readyPct;
    bit pendingRelease;
    readyTable = '{100, 80, 50, 25, 0};
    modelReset();
    $display("[TB] start, MEM_TIMEOUT=%0d", TO);

    for (int ep = 0; ep < 30; ep++) begin
      readyPct = readyTable[ep % 5];
      pendingRelease = 1'b0;
      doReset();
      for (int cyc = 0; cyc < 150; cyc++) begin
        @(negedge clk);
        if (pendingRelease) begin
          rstn = 1'b1;
          pendingRelease = 1'b0;
        end
        applyStimulus(readyPct, (ep % 2 == 0) ? 95 : 70);
        #1;
        checkAll();
        if ((ep % 3 == 1) && (cyc == 40 + ep)) begin
          #2;
          rstn = 1'b0;
          #1;
          modelReset();
          checkAll();
          pendingRelease = 1'b1;
        end else begin
          modelStep();
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
